rr_arbiter_4: RTL

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 116 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and a per-grant hold limit.
// The current holder is always lowest priority when the grant rotates.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] probe;
  logic       holder_req;
  logic       others_req;

  // Search from ptr upward; descending offsets so the smallest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    probe     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      probe = ptr_q + 2'(i);
      if (req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  assign holder_req = req[gnt_id_q];
  assign others_req = |(req & ~gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      cnt_q       <= 8'd0;
      gnt_id_q    <= 2'd0;
      gnt_q       <= 4'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StGrant;
          ptr_d       = win_idx + 2'd1;
          cnt_d       = 8'd0;
          gnt_id_d    = win_idx;
          gnt_d       = 4'b0001 << win_idx;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = 4'd0;
          gnt_valid_d = 1'b0;
        end
      end
      StGrant: begin
        // Release wins over forced rotation; ptr already points past the holder.
        if (!holder_req || (cnt_q == HoldMax && others_req)) begin
          if (win_found) begin
            ptr_d       = win_idx + 2'd1;
            cnt_d       = 8'd0;
            gnt_id_d    = win_idx;
            gnt_d       = 4'b0001 << win_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = StIdle;
            cnt_d       = 8'd0;
            gnt_d       = 4'd0;
            gnt_valid_d = 1'b0;
          end
        end else if (cnt_q < HoldMax) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_id    = gnt_id_q;
    gnt_valid = gnt_valid_q;
  end

endmodule
